// File: rtl/cop_issue_ctrl.sv
// Issue controller/arbiter sharing one crypto compute unit between two requesters.
// Define COP_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module cop_issue_ctrl #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_rs1,
  input  logic [31:0]      req0_rs2,
  input  logic [15:0]      req0_imm,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_rs1,
  input  logic [31:0]      req1_rs2,
  input  logic [15:0]      req1_imm,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [3:0]       cu_operation,
  output logic [31:0]      cu_rs1,
  output logic [31:0]      cu_rs2,
  output logic [15:0]      cu_immediate,
  input  logic [31:0]      cu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_src,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  if (LATENCY == 0 || LATENCY > 15) begin : g_latency_check
    $error("cop_issue_ctrl: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             pick1_c;
  logic             grant_c;
  logic             cnt_last_c;

  assign cnt_last_c = (cnt == CNT_W'(1));

  // Arbiter: selects port 1 when it should win; a lone valid port always wins.
  always_comb begin
    pick1_c = 1'b0;
`ifdef COP_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      pick1_c = ~last_grant;
    end else begin
      pick1_c = req1_valid;
    end
`else
    pick1_c = req1_valid && !req0_valid;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_c)    state_nxt = ST_EXEC;
      ST_EXEC: if (cnt_last_c) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; ready is held low while reset is asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_c    = 1'b0;
    busy       = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = rst && req0_valid && !pick1_c;
        req1_ready = rst && req1_valid && pick1_c;
        grant_c    = req0_ready || req1_ready;
      end
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Compute-unit operand registers and response identity, loaded only on a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cu_operation <= 4'd0;
      cu_rs1       <= 32'd0;
      cu_rs2       <= 32'd0;
      cu_immediate <= 16'd0;
      rsp_tag      <= TAG_W'(0);
      rsp_src      <= 1'b0;
    end else if (grant_c) begin
      cu_operation <= pick1_c ? req1_op  : req0_op;
      cu_rs1       <= pick1_c ? req1_rs1 : req0_rs1;
      cu_rs2       <= pick1_c ? req1_rs2 : req0_rs2;
      cu_immediate <= pick1_c ? req1_imm : req0_imm;
      rsp_tag      <= pick1_c ? req1_tag : req0_tag;
      rsp_src      <= pick1_c;
    end
  end

  // Settle counter: loaded on grant, counts down while operands are held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= CNT_W'(0);
    end else if (grant_c) begin
      cnt <= CNT_W'(LATENCY);
    end else if (state == ST_EXEC && cnt != CNT_W'(0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Result capture on the last settle cycle; held through the response handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= 32'd0;
    end else if (state == ST_EXEC && cnt_last_c) begin
      rsp_data <= cu_out;
    end
  end

  // Last granted port; reset to 1 so port 0 takes the first contested grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else begin
      last_grant <= grant_c ? pick1_c : last_grant;
    end
  end

endmodule

// File: tb/tb_cop_issue_ctrl.sv
// Directed bench for cop_issue_ctrl: a LATENCY=2 and a LATENCY=1 instance share stimulus.
module tb_cop_issue_ctrl;

  localparam logic [3:0] OP_SHA256_SIG0 = 4'h1;
  localparam logic [3:0] OP_AES_MID     = 4'h4;
  localparam logic [3:0] OP_LOAD_LLI    = 4'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic [31:0] req0_rs1 = 32'd0, req0_rs2 = 32'd0, req1_rs1 = 32'd0, req1_rs2 = 32'd0;
  logic [15:0] req0_imm = 16'd0, req1_imm = 16'd0;
  logic [3:0]  req0_tag = 4'd0, req1_tag = 4'd0;
  logic        rsp_ready = 1'b0;

  logic        a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_src, a_busy;
  logic [3:0]  a_cu_operation, a_rsp_tag;
  logic [31:0] a_cu_rs1, a_cu_rs2, a_cu_out, a_rsp_data;
  logic [15:0] a_cu_immediate;
  logic        b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_src, b_busy;
  logic [3:0]  b_cu_operation, b_rsp_tag;
  logic [31:0] b_cu_rs1, b_cu_rs2, b_cu_out, b_rsp_data;
  logic [15:0] b_cu_immediate;

  int n_tests = 0;
  int n_fail  = 0;
  int held_a  = 0;
  int held_b  = 0;
  int gap;
  int seen;
  logic src;
  logic [31:0] exp_src;

  always #5 clk = ~clk;

  cop_issue_ctrl #(.LATENCY(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_tag(req1_tag),
    .cu_operation(a_cu_operation), .cu_rs1(a_cu_rs1), .cu_rs2(a_cu_rs2),
    .cu_immediate(a_cu_immediate), .cu_out(a_cu_out),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
    .rsp_tag(a_rsp_tag), .rsp_src(a_rsp_src), .busy(a_busy)
  );

  cop_issue_ctrl #(.LATENCY(1), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_tag(req1_tag),
    .cu_operation(b_cu_operation), .cu_rs1(b_cu_rs1), .cu_rs2(b_cu_rs2),
    .cu_immediate(b_cu_immediate), .cu_out(b_cu_out),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
    .rsp_tag(b_rsp_tag), .rsp_src(b_rsp_src), .busy(b_busy)
  );

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] cu_model(input logic [3:0] op, input logic [31:0] rs1,
                                           input logic [31:0] rs2, input logic [15:0] imm);
    case (op)
      OP_SHA256_SIG0: return sig0(rs1);
      OP_LOAD_LLI:    return {rs1[31:16], imm};
      OP_AES_MID:     return rs1 ^ rs2 ^ {16'h0, imm};
      default:        return rs1 + rs2 + {28'h0, op};
    endcase
  endfunction

  // Busy-cycle counters: the unit result is correct only on the cycle it should be sampled.
  always @(negedge clk) begin
    held_a <= a_busy ? held_a + 1 : 0;
    held_b <= b_busy ? held_b + 1 : 0;
  end

  always_comb begin
    a_cu_out = cu_model(a_cu_operation, a_cu_rs1, a_cu_rs2, a_cu_immediate);
    if (held_a != 2) a_cu_out = ~a_cu_out;
    b_cu_out = cu_model(b_cu_operation, b_cu_rs1, b_cu_rs2, b_cu_immediate);
    if (held_b != 1) b_cu_out = ~b_cu_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Waits (bounded) for the next grant on one instance; steps past it before returning.
  task automatic next_grant(input bit on_b, output int g_gap, output logic g_src);
    logic g;
    #1;
    g_gap = 0;
    g = on_b ? (b_req0_ready | b_req1_ready) : (a_req0_ready | a_req1_ready);
    while (!g && g_gap < 12) begin
      step();
      g_gap++;
      g = on_b ? (b_req0_ready | b_req1_ready) : (a_req0_ready | a_req1_ready);
    end
    g_src = on_b ? b_req1_ready : a_req1_ready;
    chk("grant_seen", 32'(g), 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests pending while reset is held.
    #2;
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    chk("rst_ready0", 32'(a_req0_ready), 32'd0);
    chk("rst_ready1", 32'(a_req1_ready), 32'd0);
    chk("rst_cu_op", 32'(a_cu_operation), 32'd0);
    chk("rst_cu_rs1", a_cu_rs1, 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_data", a_rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(a_rsp_tag), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    step();

    // Single request on port 0, LATENCY=2 (and LATENCY=1 on the second instance).
    req0_op = OP_SHA256_SIG0; req0_rs1 = 32'h6A09E667; req0_rs2 = 32'd0;
    req0_imm = 16'd0; req0_tag = 4'd3; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("t1_ready0", 32'(a_req0_ready), 32'd1);
    chk("t1_ready1", 32'(a_req1_ready), 32'd0);
    chk("t1_cu_pre", 32'(a_cu_operation), 32'd0);
    step();
    req0_valid = 1'b0;
    chk("t1_cu_op", 32'(a_cu_operation), 32'(OP_SHA256_SIG0));
    chk("t1_cu_rs1", a_cu_rs1, 32'h6A09E667);
    chk("t1_busy", 32'(a_busy), 32'd1);
    chk("t1_valid_t1", 32'(a_rsp_valid), 32'd0);
    chk("l1_valid_t1", 32'(b_rsp_valid), 32'd0);
    step();
    chk("t1_valid_t2", 32'(a_rsp_valid), 32'd0);
    chk("l1_valid_t2", 32'(b_rsp_valid), 32'd1);
    chk("l1_data", b_rsp_data, sig0(32'h6A09E667));
    chk("l1_tag", 32'(b_rsp_tag), 32'd3);
    chk("l1_src", 32'(b_rsp_src), 32'd0);
    step();
    chk("t1_valid_t3", 32'(a_rsp_valid), 32'd1);
    chk("t1_data", a_rsp_data, sig0(32'h6A09E667));
    chk("t1_tag", 32'(a_rsp_tag), 32'd3);
    chk("t1_src", 32'(a_rsp_src), 32'd0);
    step();
    chk("t1_idle_busy", 32'(a_busy), 32'd0);
    chk("t1_idle_valid", 32'(a_rsp_valid), 32'd0);
    chk("t1_cu_keep", 32'(a_cu_operation), 32'(OP_SHA256_SIG0));

    // Contention on the LATENCY=2 instance: four grants spaced 4 cycles.
    apply_reset();
    req0_tag = 4'd1; req1_tag = 4'd2; req1_op = 4'h2; req1_rs1 = 32'h510E527F;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_grant(1'b0, gap, src);
`ifdef COP_ARB_RR_EN
      exp_src = 32'(k % 2);
`else
      exp_src = 32'd0;
`endif
      chk("arb_a_src", 32'(src), exp_src);
      if (k > 0) chk("arb_a_gap", 32'(gap), 32'd3);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) step();

    // Contention on the LATENCY=1 instance: grants spaced exactly 3 cycles.
    apply_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_grant(1'b1, gap, src);
`ifdef COP_ARB_RR_EN
      exp_src = 32'(k % 2);
`else
      exp_src = 32'd0;
`endif
      chk("arb_b_src", 32'(src), exp_src);
      if (k > 0) chk("arb_b_gap", 32'(gap), 32'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) step();

    // Backpressure on port 1 with both ports pending during EXEC/RESP.
    req1_op = OP_LOAD_LLI; req1_rs1 = 32'hCAFE0000; req1_rs2 = 32'd0;
    req1_imm = 16'h1234; req1_tag = 4'd9; req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("bp_grant1", 32'(a_req1_ready), 32'd1);
    chk("bp_grant0", 32'(a_req0_ready), 32'd0);
    step();
    req0_valid = 1'b1;
    #1;
    chk("bp_exec_ready0", 32'(a_req0_ready), 32'd0);
    chk("bp_exec_ready1", 32'(a_req1_ready), 32'd0);
    step();
    chk("bp_valid_t2", 32'(a_rsp_valid), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_data", a_rsp_data, 32'hCAFE1234);
      chk("bp_tag", 32'(a_rsp_tag), 32'd9);
      chk("bp_src", 32'(a_rsp_src), 32'd1);
      chk("bp_ready0", 32'(a_req0_ready), 32'd0);
      chk("bp_ready1", 32'(a_req1_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_valid", 32'(a_rsp_valid), 32'd1);
    chk("hs_ready0", 32'(a_req0_ready), 32'd0);
    chk("hs_ready1", 32'(a_req1_ready), 32'd0);
    step();
    chk("hs_idle_busy", 32'(a_busy), 32'd0);
    chk("hs_idle_valid", 32'(a_rsp_valid), 32'd0);
    chk("hs_next_ready0", 32'(a_req0_ready), 32'd1);
    chk("hs_next_ready1", 32'(a_req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("drop_not_committed", 32'(a_busy), 32'd0);
    repeat (4) step();

    // Reset asserted during EXEC of an AES op.
    req0_op = OP_AES_MID; req0_rs1 = 32'h00112233; req0_rs2 = 32'h44556677;
    req0_imm = 16'h0002; req0_tag = 4'd5; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("rm_grant", 32'(a_req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    chk("rm_busy_pre", 32'(a_busy), 32'd1);
    chk("rm_op_pre", 32'(a_cu_operation), 32'(OP_AES_MID));
    rst = 1'b0;
    #1;
    chk("rm_busy_async", 32'(a_busy), 32'd0);
    chk("rm_valid_async", 32'(a_rsp_valid), 32'd0);
    chk("rm_op_async", 32'(a_cu_operation), 32'd0);
    chk("rm_rs1_async", a_cu_rs1, 32'd0);
    step();
    step();
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      step();
      if (a_rsp_valid) seen++;
    end
    chk("rm_no_rsp", 32'(seen), 32'd0);
    chk("rm_busy_after", 32'(a_busy), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rm_arb_ready0", 32'(a_req0_ready), 32'd1);
    chk("rm_arb_ready1", 32'(a_req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
